// File: rtl/alu_ctrl_sequencer_pkg.sv
// Shared definitions for the ALU control sequencer: control codes, funct
// encodings, main-decoder op classes and the sequencer state type.
package alu_ctrl_pkg;

    // ALU control words
    localparam logic [3:0] ALU_AND      = 4'b0000;
    localparam logic [3:0] ALU_OR       = 4'b0001;
    localparam logic [3:0] ALU_ADD      = 4'b0010;
    localparam logic [3:0] ALU_SUB      = 4'b0110;
    localparam logic [3:0] ALU_SLT      = 4'b0111;
    localparam logic [3:0] ALU_MUL_STEP = 4'b1000;
    localparam logic [3:0] ALU_DIV_STEP = 4'b1010;
    localparam logic [3:0] ALU_NOR      = 4'b1100;
    localparam logic [3:0] ALU_ILLEGAL  = 4'b1111;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    // Main-decoder op classes
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_LOGIC = 2'b11;

    typedef enum logic {
        IDLE,
        STEP
    } seq_state_t;

endpackage

// File: rtl/alu_ctrl_sequencer_if.sv
// Instruction-in / step-out handshake bundle between the decode stage,
// the sequencer and the ALU datapath.
interface alu_ctrl_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] opcode;
    logic [5:0] funct;
    logic       sel;
    logic [3:0] alu_cnt;
    logic       out_valid;
    logic       out_ready;
    logic       step_last;
    logic       err;

    // Environment side: issues instructions and consumes steps
    modport master (
        output in_valid, opcode, funct, sel, out_ready,
        input  in_ready, alu_cnt, out_valid, step_last, err
    );

    // Sequencer side
    modport slave (
        input  in_valid, opcode, funct, sel, out_ready,
        output in_ready, alu_cnt, out_valid, step_last, err
    );
endinterface

// File: rtl/alu_ctrl_sequencer_decode.sv
// Combinational instruction decoder: {opcode, funct, sel} to control code,
// step count and illegal flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_STEPS = 8,
    parameter int unsigned DIV_STEPS = 8
) (
    input  logic [1:0] opcode,
    input  logic [5:0] funct,
    input  logic       sel,
    output logic [3:0] code,
    output logic [4:0] steps,
    output logic       illegal
);

    localparam logic [4:0] MUL_N = 5'(MUL_STEPS);
    localparam logic [4:0] DIV_N = 5'(DIV_STEPS);

    // Map the instruction fields onto a control word and its step count
    always_comb begin
        code    = ALU_ADD;
        steps   = 5'd1;
        illegal = 1'b0;
        unique case (opcode)
            OP_ADD:   code = ALU_ADD;
            OP_SUB:   code = ALU_SUB;
            OP_LOGIC: code = sel ? ALU_OR : ALU_AND;
            OP_RTYPE: begin
                unique case (funct)
                    FUNCT_ADD: code = ALU_ADD;
                    FUNCT_SUB: code = ALU_SUB;
                    FUNCT_AND: code = ALU_AND;
                    FUNCT_OR:  code = ALU_OR;
                    FUNCT_SLT: code = ALU_SLT;
                    FUNCT_NOR: code = ALU_NOR;
                    FUNCT_MUL: begin
                        code  = ALU_MUL_STEP;
                        steps = MUL_N;
                    end
                    FUNCT_DIV: begin
                        code  = ALU_DIV_STEP;
                        steps = DIV_N;
                    end
                    default: begin
                        code    = ALU_ILLEGAL;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Registered, handshaked ALU control sequencer. Accepts one instruction per
// handshake and emits one or more control steps to the datapath, stalling on
// datapath back-pressure.
module alu_ctrl_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_STEPS = 8,
    parameter int unsigned DIV_STEPS = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_ctrl_sequencer_if.slave bus
);

    seq_state_t state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] alu_cnt_q, alu_cnt_d;
    logic       err_q, err_d;
    logic       out_valid_q, out_valid_d;

    logic [3:0] dec_code;
    logic [4:0] dec_steps;
    logic       dec_illegal;
    logic       last;
    logic       consume;
    logic       accept;

    alu_ctrl_decode #(
        .MUL_STEPS (MUL_STEPS),
        .DIV_STEPS (DIV_STEPS)
    ) u_decode (
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .sel     (bus.sel),
        .code    (dec_code),
        .steps   (dec_steps),
        .illegal (dec_illegal)
    );

    assign last         = out_valid_q && (remaining_q == '0);
    assign consume      = out_valid_q && bus.out_ready;
    assign bus.in_ready = (state_q == IDLE) || (consume && last);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.alu_cnt   = alu_cnt_q;
    assign bus.err       = err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.step_last = last;

    // Next-state: load on accept, count down consumed steps, hold on stall
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        alu_cnt_d   = alu_cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = STEP;
                    alu_cnt_d   = dec_code;
                    err_d       = dec_illegal;
                    remaining_d = 4'(dec_steps - 5'd1);
                    out_valid_d = 1'b1;
                end
            end
            STEP: begin
                if (consume) begin
                    if (last) begin
                        // Final step consumed: chain straight into the next
                        // instruction when one is waiting, else go idle.
                        if (accept) begin
                            alu_cnt_d   = dec_code;
                            err_d       = dec_illegal;
                            remaining_d = 4'(dec_steps - 5'd1);
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                        end
                    end else if (remaining_q != '0) begin
                        remaining_d = remaining_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            alu_cnt_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            alu_cnt_q   <= alu_cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench for alu_ctrl_sequencer: scoreboard of expected steps
// derived from the decode rules, checked by an independent monitor.
module tb_alu_ctrl_sequencer;

    localparam int N_MUL = 8;
    localparam int N_DIV = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_sequencer_if bus ();
    alu_ctrl_sequencer_if bus_a ();
    alu_ctrl_sequencer_if bus_b ();

    alu_ctrl_sequencer #(.MUL_STEPS(N_MUL), .DIV_STEPS(N_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_ctrl_sequencer #(.MUL_STEPS(2), .DIV_STEPS(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    alu_ctrl_sequencer #(.MUL_STEPS(16), .DIV_STEPS(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        logic [3:0] code;
        logic       err;
        logic       last;
    } step_t;

    step_t       sbq[$];
    int          checks      = 0;
    int          errors      = 0;
    int unsigned ready_pct   = 100;
    int          cycle       = 0;
    int          stall_start = -100;
    int          stall_len   = 0;
    logic [5:0]  flist[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written directly from the instruction table
    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f, input logic s,
                                       output logic [3:0] code, output int n, output logic e);
        n = 1;
        e = 1'b0;
        if (op == 2'b00)      code = 4'b0010;
        else if (op == 2'b01) code = 4'b0110;
        else if (op == 2'b11) code = s ? 4'b0001 : 4'b0000;
        else begin
            case (f)
                6'b100000: code = 4'b0010;
                6'b100010: code = 4'b0110;
                6'b100100: code = 4'b0000;
                6'b100101: code = 4'b0001;
                6'b101010: code = 4'b0111;
                6'b100111: code = 4'b1100;
                6'b011000: begin code = 4'b1000; n = N_MUL; end
                6'b011010: begin code = 4'b1010; n = N_DIV; end
                default:   begin code = 4'b1111; e = 1'b1; end
            endcase
        end
    endfunction

    // Datapath back-pressure: random readiness plus an optional forced stall window
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            if (cycle >= stall_start && cycle < stall_start + stall_len)
                bus.out_ready = 1'b0;
            else
                bus.out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: compare what the DUT presents against the scoreboard head
    initial begin
        step_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() == 0) begin
                chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
                chk("idle_step_last", 32'(bus.step_last), 32'd0);
                chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
            end else begin
                e = sbq[0];
                chk("out_valid", 32'(bus.out_valid), 32'd1);
                chk("alu_cnt", 32'(bus.alu_cnt), 32'(e.code));
                chk("err", 32'(bus.err), 32'(e.err));
                chk("step_last", 32'(bus.step_last), 32'(e.last));
                chk("busy_in_ready", 32'(bus.in_ready), 32'(bus.out_ready && e.last));
                if (bus.out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic s,
                         output int waits, input bit sync);
        bit         ok = 1'b0;
        logic [3:0] c;
        int         n;
        logic       e;
        step_t      st;
        if (sync) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.funct    = f;
        bus.sel      = s;
        waits        = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            #4;
            if (bus.in_ready) begin
                ok = 1'b1;
                ref_decode(op, f, s, c, n, e);
                for (int i = 0; i < n; i++) begin
                    st.code = c;
                    st.err  = e;
                    st.last = (i == n - 1);
                    sbq.push_back(st);
                end
            end else begin
                @(negedge clk);
                waits++;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept at %0t", $time);
        end
    endtask

    task automatic scramble_idle();
        bus.in_valid = 1'b0;
        bus.opcode   = 2'($urandom);
        bus.funct    = 6'($urandom);
        bus.sel      = 1'($urandom);
    endtask

    // Cycles from accept until the final step is consumed
    task automatic measure(input bit stall, output int cyc);
        bit done = 1'b0;
        cyc = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            scramble_idle();
            #4;
            cyc++;
            if (stall && cyc == 3) begin
                stall_start = cycle + 1;
                stall_len   = 3;
            end
            if (bus.out_valid && bus.out_ready && bus.step_last) done = 1'b1;
        end
        chk("measure_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #4;
            if (sbq.size() == 0) ok = 1'b1;
        end
        chk("drain_timeout", 32'(ok), 32'd1);
    endtask

    task automatic sw_drive(input int which, input logic v, input logic [5:0] f);
        if (which == 0) begin
            bus_a.in_valid = v; bus_a.opcode = 2'b10; bus_a.funct = f; bus_a.sel = 1'b0;
        end else begin
            bus_b.in_valid = v; bus_b.opcode = 2'b10; bus_b.funct = f; bus_b.sel = 1'b0;
        end
    endtask

    // {in_ready, out_valid, step_last, alu_cnt}
    function automatic logic [6:0] sw_sig(input int which);
        if (which == 0) return {bus_a.in_ready, bus_a.out_valid, bus_a.step_last, bus_a.alu_cnt};
        return {bus_b.in_ready, bus_b.out_valid, bus_b.step_last, bus_b.alu_cnt};
    endfunction

    task automatic sweep(input int which, input logic [5:0] f, input int exp_n, input logic [3:0] exp_code);
        logic [6:0] sg;
        int         n    = 0;
        bit         done = 1'b0;
        @(negedge clk);
        sw_drive(which, 1'b1, f);
        #4;
        sg = sw_sig(which);
        chk("sweep_accept", 32'(sg[6]), 32'd1);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            sw_drive(which, 1'b0, 6'($urandom));
            #4;
            sg = sw_sig(which);
            if (sg[5]) begin
                n++;
                chk("sweep_code", 32'(sg[3:0]), 32'(exp_code));
                chk("sweep_last", 32'(sg[4]), 32'(n == exp_n));
                if (sg[4] || n >= exp_n) done = 1'b1;
            end
        end
        chk("sweep_steps", 32'(n), 32'(exp_n));
        @(negedge clk);
        #4;
        sg = sw_sig(which);
        chk("sweep_no_wrap", 32'(sg[5]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         w;
        int         cyc;
        int         ov;
        logic [1:0] op;
        logic [5:0] f;
        logic       s;

        flist = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                  6'b101010, 6'b100111, 6'b011000, 6'b011010};
        bus.in_valid = 1'b0; bus.opcode = '0; bus.funct = '0; bus.sel = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.opcode = '0; bus_a.funct = '0; bus_a.sel = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.opcode = '0; bus_b.funct = '0; bus_b.sel = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_alu_cnt", 32'(bus.alu_cnt), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_step_last", 32'(bus.step_last), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(negedge clk);

        // Release with an instruction already presented; then back-to-back singles
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 6'h00, 1'b0, w, 1'b0);
        chk("first_accept_wait", 32'(w), 32'd0);
        issue(2'b01, 6'h3f, 1'b1, w, 1'b1);
        chk("b2b_sub_wait", 32'(w), 32'd0);
        issue(2'b10, 6'b100101, 1'b0, w, 1'b1);
        chk("b2b_or_wait", 32'(w), 32'd0);
        issue(2'b11, 6'h00, 1'b1, w, 1'b1);
        chk("b2b_logic_wait", 32'(w), 32'd0);

        // MUL: exactly N_MUL steps under continuous ready
        issue(2'b10, 6'b011000, 1'b0, w, 1'b1);
        chk("mul_accept_wait", 32'(w), 32'd0);
        measure(1'b0, cyc);
        chk("mul_cycles", 32'(cyc), 32'(N_MUL));

        // DIV with a 3-cycle stall mid-sequence
        issue(2'b10, 6'b011010, 1'b0, w, 1'b1);
        measure(1'b1, cyc);
        chk("div_stall_cycles", 32'(cyc), 32'(N_DIV + 3));

        // Illegal funct, then legal ops (funct ignored outside opcode 10)
        issue(2'b10, 6'b111111, 1'b0, w, 1'b1);
        issue(2'b00, 6'b111111, 1'b1, w, 1'b1);
        issue(2'b11, 6'b111111, 1'b0, w, 1'b1);
        issue(2'b10, 6'b100111, 1'b1, w, 1'b1);
        issue(2'b10, 6'b101010, 1'b0, w, 1'b1);
        drain();

        // Reset mid-MUL after three consumed steps
        issue(2'b10, 6'b011000, 1'b0, w, 1'b1);
        repeat (3) begin
            @(negedge clk);
            scramble_idle();
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("abort_alu_cnt", 32'(bus.alu_cnt), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_step_last", 32'(bus.step_last), 32'd0);
        chk("abort_err", 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        ov = 0;
        repeat (12) begin
            @(negedge clk);
            #4;
            if (bus.out_valid) ov++;
        end
        chk("abort_no_steps", 32'(ov), 32'd0);

        // Randomized traffic under random back-pressure
        ready_pct = 70;
        repeat (150) begin
            op = 2'($urandom);
            f  = ($urandom_range(3) == 0) ? 6'($urandom) : flist[$urandom_range(7)];
            s  = 1'($urandom);
            issue(op, f, s, w, 1'b1);
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(3) + 1) begin
                    @(negedge clk);
                    scramble_idle();
                end
            end
        end
        drain();
        ready_pct = 100;

        // Parameter extremes: 2 and 16 steps
        sweep(0, 6'b011000, 2, 4'b1000);
        sweep(0, 6'b011010, 16, 4'b1010);
        sweep(1, 6'b011000, 16, 4'b1000);
        sweep(1, 6'b011010, 2, 4'b1010);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
